// File: rtl/div_unit.sv
// Iterative 32-bit signed divider (MIPS div): quotient to lo, remainder to hi, 34-cycle latency.
// Optional macro DIV_UNIT_ZERO_EXC_EN: a zero divisor completes in one cycle with div_zero raised.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 6;
    localparam int unsigned LAST = 31;

    // WB is the hand-off cycle: busy already low, results land at its closing edge
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state, next_state;

    logic [W-1:0]  dvd_q;
    logic [W-1:0]  dvs_q;
    logic [W-1:0]  rem_q;
    logic [CW-1:0] cnt_q;
    logic          sign_q_q;
    logic          sign_r_q;
    logic          zero_q;

    logic          accept_c;
    logic          zero_trap_c;
    logic [W-1:0]  a_mag_c;
    logic [W-1:0]  b_mag_c;
    logic [W:0]    shifted_c;
    logic          ge_c;

    logic          busy_d;
    logic          done_d;
    logic          div_zero_d;
    logic          load_res_d;

`ifdef DIV_UNIT_ZERO_EXC_EN
    assign zero_trap_c = (state == S_IDLE) && start && (divisor == W'(0));
`else
    assign zero_trap_c = 1'b0;
`endif

    assign accept_c  = (state == S_IDLE) && start && !zero_trap_c;
    assign a_mag_c   = dividend[W-1] ? (-dividend) : dividend;
    assign b_mag_c   = divisor[W-1]  ? (-divisor)  : divisor;
    assign shifted_c = {rem_q, dvd_q[W-1]};
    assign ge_c      = shifted_c >= {1'b0, dvs_q};

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept_c) next_state = S_CALC;
            S_CALC: if (cnt_q == CW'(LAST)) next_state = S_FIX;
            S_FIX:  next_state = S_WB;
            S_WB:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // output decode, registered below
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        load_res_d = 1'b0;
        if (next_state == S_CALC || next_state == S_FIX) busy_d = 1'b1;
        if (state == S_WB) begin
            done_d     = 1'b1;
            load_res_d = 1'b1;
        end
        if (zero_trap_c) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
        end
    end

    // restoring-division datapath; FIX rewrites dvd/rem with the signed results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        dvd_q    <= a_mag_c;
                        dvs_q    <= b_mag_c;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        sign_q_q <= dividend[W-1] ^ divisor[W-1];
                        sign_r_q <= dividend[W-1];
                        zero_q   <= (divisor == W'(0));
                    end
                end
                S_CALC: begin
                    rem_q <= ge_c ? W'(shifted_c - {1'b0, dvs_q}) : shifted_c[W-1:0];
                    dvd_q <= {dvd_q[W-2:0], ge_c};
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    // zero divisor: remainder path already reproduces the dividend
                    dvd_q <= zero_q ? '1 : (sign_q_q ? (-dvd_q) : dvd_q);
                    rem_q <= sign_r_q ? (-rem_q) : rem_q;
                end
                default: ;
            endcase
        end
    end

    // registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            div_zero <= div_zero_d;
            if (load_res_d) begin
                hi <= rem_q;
                lo <= dvd_q;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; honours DIV_UNIT_ZERO_EXC_EN when defined.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is driven in the current cycle. Returns at the
    // negedge of the done cycle (or after the timeout).
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_lat, input int exp_busy, input logic exp_dz);
        int c;
        int bc;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h1234_5678;
        c  = 0;
        bc = 0;
        while (c < 60 && !done) begin
            if (busy) bc++;
            @(negedge clk);
            c++;
        end
        chk({tag, ".latency"}, 32'(c), 32'(exp_lat));
        chk({tag, ".busy_cycles"}, 32'(bc), 32'(exp_busy));
        chk({tag, ".lo"}, lo, exp_lo);
        chk({tag, ".hi"}, hi, exp_hi);
        chk({tag, ".div_zero"}, 32'(div_zero), 32'(exp_dz));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        int nd;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.flags", {29'd0, busy, done, div_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic signed cases
        do_div("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 34, 33, 1'b0);
        @(negedge clk);
        chk("p100_7.done_pulse", 32'(done), 32'd0);
        chk("p100_7.lo_hold", lo, 32'd14);
        chk("p100_7.hi_hold", hi, 32'd2);
        do_div("m100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34, 33, 1'b0);
        do_div("p100_m7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 34, 33, 1'b0);
        do_div("m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 34, 33, 1'b0);
        do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 33, 1'b0);
        do_div("min_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 34, 33, 1'b0);
        do_div("small", 32'd7, 32'd100, 32'd0, 32'd7, 34, 33, 1'b0);
        do_div("m1_min", 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 34, 33, 1'b0);

        // divide by zero
`ifdef DIV_UNIT_ZERO_EXC_EN
        do_div("z5", 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 1'b1);
        do_div("zm5", 32'hFFFF_FFFB, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 1'b1);
`else
        do_div("z5", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 34, 33, 1'b0);
        do_div("zm5", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 34, 33, 1'b0);
`endif

        // back-to-back: second start lands in the done cycle
        do_div("b2b_a", 32'd9, 32'd3, 32'd3, 32'd0, 34, 33, 1'b0);
        do_div("b2b_b", 32'd100, 32'd7, 32'd14, 32'd2, 34, 33, 1'b0);
        @(negedge clk);

        // start while busy is ignored and not queued
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < 60 && !done) begin
            if (c == 10) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            else         begin start = 1'b0; end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("ign.latency", 32'(c), 32'd34);
        chk("ign.lo", lo, 32'd14);
        chk("ign.hi", hi, 32'd2);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("ign.no_queue", 32'(nd), 32'd0);

        // reset in the middle of an operation
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        repeat (20) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("rmid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmid.hi", hi, 32'd0);
        chk("rmid.lo", lo, 32'd0);
        chk("rmid.flags", {29'd0, busy, done, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("rmid.no_done", 32'(nd), 32'd0);
        do_div("post_rst", 32'd9, 32'd3, 32'd3, 32'd0, 34, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
